lane_tx_framer: RTL and testbench

Per-lane transmit framer that turns the initialisation controller's `ordered_sets` request into a continuous 2-byte/cycle symbol stream for the 8B/10B encoder, and passes user data once the channel is ready. It sits between the channel initialisation FSM and the lane encoder/serialiser. It also inserts periodic clock-compensation (CC) bursts. Every cycle it emits exactly one symbol pair.

---
 rtl/lane_tx_framer.sv | 181 ++++++++++++++++++
 tb/tb_lane_tx_framer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/lane_tx_framer.sv
// Per-lane transmit framer: turns the channel-init ordered-set request into a
// continuous 2-byte/cycle symbol stream (SP / VER / idle / user data) for the
// 8B/10B encoder, and splices in periodic clock-compensation bursts.

package aurora_pkg;
    typedef struct packed {
        logic sp;
        logic ver;
        logic i;
    } ordered_sets_t;
endpackage

module lane_tx_framer
    import aurora_pkg::*;
#(
    parameter int CC_PERIOD = 5000,
    parameter int CC_LEN    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  ordered_sets_t ordered_sets,
    input  logic [15:0]   tx_user_data,
    input  logic          tx_user_valid,
    output logic          tx_user_ready,
    output logic [15:0]   tx_data,
    output logic [1:0]    tx_charisk
);

    localparam int CNT_W  = $clog2(CC_PERIOD);
    localparam int LEFT_W = $clog2(CC_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CC_PERIOD - 1);
    localparam logic [LEFT_W-1:0] LEFT_INIT = LEFT_W'(CC_LEN - 1);
    localparam logic              CC_MULTI  = (CC_LEN > 1) ? 1'b1 : 1'b0;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_0 = 8'h1C;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K23_7 = 8'hF7;
    localparam logic [7:0] D21_4 = 8'h95;
    localparam logic [7:0] D21_5 = 8'hB5;
    localparam logic [7:0] D14_3 = 8'h6E;
    localparam logic [7:0] D10_2 = 8'h4A;

    // Position inside a 2-cycle ordered set; the second-half states remember
    // which set is being finished so a mid-set request change cannot truncate it.
    typedef enum logic [1:0] {
        ST_BOUNDARY = 2'b00,
        ST_SP_2ND   = 2'b01,
        ST_VER_2ND  = 2'b10
    } set_state_t;

    set_state_t        state_r, state_n;
    logic [15:0]       tx_data_r, tx_data_n;
    logic [1:0]        tx_charisk_r, tx_charisk_n;
    logic [6:0]        lfsr_r, lfsr_n;
    logic [CNT_W-1:0]  cc_cnt_r, cc_cnt_n;
    logic [LEFT_W-1:0] cc_left_r, cc_left_n;
    logic              cc_pending_r, cc_pending_n;
    logic              cc_active_r, cc_active_n;
    logic              phase_s;
    logic              data_mode_s;
    logic              cc_wrap_s;

    // Idle K-symbol selected by two LFSR bits.
    function automatic logic [7:0] idle_sym(input logic [1:0] sel);
        logic [7:0] sym;
        case (sel)
            2'b00:   sym = K28_5;
            2'b01:   sym = K28_5;
            2'b10:   sym = K28_0;
            2'b11:   sym = K28_3;
            default: sym = K28_5;
        endcase
        return sym;
    endfunction

    // One step of the x^7+x^6+1 Fibonacci LFSR.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s);
        return {s[5:0], s[6] ^ s[5]};
    endfunction

    assign phase_s     = (state_r != ST_BOUNDARY);
    assign data_mode_s = ~(ordered_sets.sp | ordered_sets.ver | ordered_sets.i);
    assign cc_wrap_s   = (cc_cnt_r == CNT_MAX);

    // Ready only when a user word would actually be emitted at the next edge.
    always_comb begin
        tx_user_ready = rst_n & data_mode_s & ~phase_s & ~cc_active_r & ~cc_pending_r;
    end

    // Next-state and next-output selection: CC burst > set completion > new mode.
    always_comb begin
        state_n      = state_r;
        tx_data_n    = tx_data_r;
        tx_charisk_n = tx_charisk_r;
        lfsr_n       = lfsr_r;
        cc_left_n    = cc_left_r;
        cc_active_n  = cc_active_r;
        cc_pending_n = cc_pending_r | cc_wrap_s;
        cc_cnt_n     = cc_wrap_s ? {CNT_W{1'b0}} : (cc_cnt_r + CNT_W'(1));

        if (cc_active_r) begin
            tx_data_n    = {K23_7, K23_7};
            tx_charisk_n = 2'b11;
            if (cc_left_r <= LEFT_W'(1)) begin
                cc_active_n = 1'b0;
                cc_left_n   = {LEFT_W{1'b0}};
            end else begin
                cc_left_n   = cc_left_r - LEFT_W'(1);
            end
        end else begin
            case (state_r)
                ST_SP_2ND: begin
                    tx_data_n    = {D21_5, D21_5};
                    tx_charisk_n = 2'b00;
                    state_n      = ST_BOUNDARY;
                end
                ST_VER_2ND: begin
                    tx_data_n    = {D10_2, D10_2};
                    tx_charisk_n = 2'b00;
                    state_n      = ST_BOUNDARY;
                end
                ST_BOUNDARY: begin
                    if (cc_pending_r) begin
                        // Burst start; a wrap in this very cycle re-arms pending.
                        tx_data_n    = {K23_7, K23_7};
                        tx_charisk_n = 2'b11;
                        cc_active_n  = CC_MULTI;
                        cc_left_n    = LEFT_INIT;
                        cc_pending_n = cc_wrap_s;
                    end else if (ordered_sets.sp) begin
                        tx_data_n    = {K28_5, D21_4};
                        tx_charisk_n = 2'b10;
                        state_n      = ST_SP_2ND;
                    end else if (ordered_sets.ver) begin
                        tx_data_n    = {K28_5, D14_3};
                        tx_charisk_n = 2'b10;
                        state_n      = ST_VER_2ND;
                    end else if (!ordered_sets.i && tx_user_valid && tx_user_ready) begin
                        tx_data_n    = tx_user_data;
                        tx_charisk_n = 2'b00;
                    end else begin
                        tx_data_n    = {idle_sym(lfsr_r[1:0]), idle_sym(lfsr_r[3:2])};
                        tx_charisk_n = 2'b11;
                        lfsr_n       = lfsr_step(lfsr_r);
                    end
                end
                default: begin
                    state_n = ST_BOUNDARY;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_BOUNDARY;
            tx_data_r    <= 16'h0000;
            tx_charisk_r <= 2'b00;
            lfsr_r       <= 7'h7F;
            cc_cnt_r     <= {CNT_W{1'b0}};
            cc_left_r    <= {LEFT_W{1'b0}};
            cc_pending_r <= 1'b0;
            cc_active_r  <= 1'b0;
        end else begin
            state_r      <= state_n;
            tx_data_r    <= tx_data_n;
            tx_charisk_r <= tx_charisk_n;
            lfsr_r       <= lfsr_n;
            cc_cnt_r     <= cc_cnt_n;
            cc_left_r    <= cc_left_n;
            cc_pending_r <= cc_pending_n;
            cc_active_r  <= cc_active_n;
        end
    end

    assign tx_data    = tx_data_r;
    assign tx_charisk = tx_charisk_r;

endmodule

// File: tb/tb_lane_tx_framer.sv
// Directed bench for lane_tx_framer with a short CC period (20) so CC bursts
// occur within a few dozen cycles; each scenario starts from reset.

module tb_lane_tx_framer;
    import aurora_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    ordered_sets_t os;
    logic [15:0]   ud;
    logic          uv;
    logic          ur;
    logic [15:0]   txd;
    logic [1:0]    txk;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [2:0] OS_NONE = 3'b000;
    localparam logic [2:0] OS_SP   = 3'b100;
    localparam logic [2:0] OS_VER  = 3'b010;
    localparam logic [2:0] OS_I    = 3'b001;

    lane_tx_framer #(.CC_PERIOD(20), .CC_LEN(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ordered_sets  (os),
        .tx_user_data  (ud),
        .tx_user_valid (uv),
        .tx_user_ready (ur),
        .tx_data       (txd),
        .tx_charisk    (txk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] d, input logic [1:0] k);
        chk({tag, "_data"}, txd, d);
        chk({tag, "_k"}, {14'd0, txk}, {14'd0, k});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        os    = OS_NONE;
        uv    = 1'b0;
        ud    = 16'h0000;
        tick();
        tick();
    endtask

    initial begin
        logic [15:0] exp_d;
        logic [1:0]  exp_k;
        logic        rdy_exp;

        rst_n = 1'b0;
        os    = OS_NONE;
        uv    = 1'b1;
        ud    = 16'h0000;

        // Reset state
        tick();
        tick();
        chk_out("rst", 16'h0000, 2'b00);
        chk("rst_ready", {15'd0, ur}, 16'h0000);
        chk("rst_lfsr", {9'd0, dut.lfsr_r}, 16'h007F);

        // SP held for 6 cycles
        hold_reset();
        os    = OS_SP;
        rst_n = 1'b1;
        #1 chk("sp_ready", {15'd0, ur}, 16'h0000);
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c % 2 == 1) chk_out("sp_a", 16'hBC95, 2'b10);
            else            chk_out("sp_b", 16'hB5B5, 2'b00);
        end

        // SP -> VER change during phase 1: SP set completes first
        hold_reset();
        os    = OS_SP;
        rst_n = 1'b1;
        tick(); chk_out("sw_sp_a", 16'hBC95, 2'b10);
        os = OS_VER;
        tick(); chk_out("sw_sp_b", 16'hB5B5, 2'b00);
        tick(); chk_out("sw_ver_a", 16'hBC6E, 2'b10);
        tick(); chk_out("sw_ver_b", 16'h4A4A, 2'b00);
        tick(); chk_out("sw_ver_a2", 16'hBC6E, 2'b10);

        // SP+VER together -> SP wins; then I with LFSR from seed 7F
        hold_reset();
        os    = OS_SP | OS_VER;
        rst_n = 1'b1;
        tick(); chk_out("pri_a", 16'hBC95, 2'b10);
        tick(); chk_out("pri_b", 16'hB5B5, 2'b00);
        os = OS_I;
        tick(); chk_out("idle0", 16'h7C7C, 2'b11);
        tick(); chk_out("idle1", 16'h1C7C, 2'b11);
        tick(); chk_out("idle2", 16'hBC7C, 2'b11);
        tick(); chk_out("idle3", 16'hBC1C, 2'b11);
        tick(); chk_out("idle4", 16'hBCBC, 2'b11);

        // Data mode with valid low emits idles; a data cycle does not advance LFSR
        hold_reset();
        os    = OS_NONE;
        uv    = 1'b0;
        rst_n = 1'b1;
        tick(); chk_out("dv_idle0", 16'h7C7C, 2'b11);
        uv = 1'b1;
        ud = 16'h1234;
        #1 chk("dv_ready", {15'd0, ur}, 16'h0001);
        tick(); chk_out("dv_data", 16'h1234, 2'b00);
        uv = 1'b0;
        tick(); chk_out("dv_idle1", 16'h1C7C, 2'b11);
        tick(); chk_out("dv_idle2", 16'hBC7C, 2'b11);

        // Streaming data across a CC burst (wrap at edge 20, burst edges 21..26)
        hold_reset();
        os      = OS_NONE;
        uv      = 1'b1;
        ud      = 16'h0001;
        rst_n   = 1'b1;
        rdy_exp = 1'b1;
        #1 chk("cc_ready0", {15'd0, ur}, 16'h0001);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k <= 20) begin
                exp_d = 16'(k);
                exp_k = 2'b00;
            end else if (k <= 26) begin
                exp_d = 16'hF7F7;
                exp_k = 2'b11;
            end else begin
                exp_d = 16'(k - 6);
                exp_k = 2'b00;
            end
            chk_out($sformatf("cc_e%0d", k), exp_d, exp_k);
            if (rdy_exp) ud = ud + 16'h0001;
            rdy_exp = !(k >= 20 && k <= 25);
            #1 chk($sformatf("cc_rdy%0d", k), {15'd0, ur}, {15'd0, rdy_exp});
        end

        // CC wrap in an SP phase-1 cycle, then reset mid-burst
        hold_reset();
        os    = OS_SP;
        rst_n = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c % 2 == 1) chk_out($sformatf("ccsp_a%0d", c), 16'hBC95, 2'b10);
            else            chk_out($sformatf("ccsp_b%0d", c), 16'hB5B5, 2'b00);
        end
        tick(); chk_out("ccsp_cc21", 16'hF7F7, 2'b11);
        tick(); chk_out("ccsp_cc22", 16'hF7F7, 2'b11);
        rst_n = 1'b0;
        tick();
        chk_out("mid_rst", 16'h0000, 2'b00);
        chk("mid_rst_ready", {15'd0, ur}, 16'h0000);
        chk("mid_rst_phase", {15'd0, dut.phase_s}, 16'h0000);
        chk("mid_rst_lfsr", {9'd0, dut.lfsr_r}, 16'h007F);
        chk("mid_rst_cnt", {11'd0, dut.cc_cnt_r}, 16'h0000);
        chk("mid_rst_pend", {15'd0, dut.cc_pending_r}, 16'h0000);
        chk("mid_rst_act", {15'd0, dut.cc_active_r}, 16'h0000);
        rst_n = 1'b1;
        tick(); chk_out("post_rst_a", 16'hBC95, 2'b10);
        tick(); chk_out("post_rst_b", 16'hB5B5, 2'b00);
        tick(); chk_out("post_rst_a2", 16'hBC95, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
